// File: rtl/mac_pkg.sv
// mac_pkg: shared state enum, operand/product widths and saturation bounds
package mac_pkg;
  typedef enum logic {ST_ACCUM, ST_DONE} state_e;
  localparam int OPND_W = 17;
  localparam int PROD_W = 34;
  localparam int SAT_MAX = 65535;
  localparam int SAT_MIN = -65536;
endpackage

// File: rtl/mac_round_sat.sv
// mac_round_sat: round-half-up acc_i by FRAC bits, clamp to 17-bit signed; res_o result, sat_o clamped
module mac_round_sat
  import mac_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int FRAC = 8
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [OPND_W-1:0] res_o,
  output logic              sat_o
);
  localparam logic [ACC_W:0] HALF = ((ACC_W+1)'(1) << FRAC) >> 1;
  localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(SAT_MAX);
  localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(SAT_MIN);
  logic signed [ACC_W:0] r;
  logic hi, lo;
  assign r = ($signed({acc_i[ACC_W-1], acc_i}) + $signed(HALF)) >>> FRAC;
  assign hi = r > HI;
  assign lo = r < LO;
  assign sat_o = hi | lo;
  assign res_o = hi ? OPND_W'(SAT_MAX) : lo ? OPND_W'(SAT_MIN) : r[OPND_W-1:0];
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums batches of mul products (in_* handshake), emits rounded saturated result (out_* handshake)
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W = 40,
  parameter int FRAC = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PROD_W-1:0]              in_prod,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OPND_W-1:0]              out_data,
  output logic                           out_sat,
  output logic [$clog2(N_TERMS+1)-1:0]   out_count
);
  localparam int CW = $clog2(N_TERMS+1);
  state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc, count_q, count_d;
  logic [OPND_W-1:0] data_q, data_d, rs_data;
  logic sat_q, sat_d, rs_sat, in_fire, out_fire, close;
  assign in_ready = state_q == ST_ACCUM;
  assign out_valid = state_q == ST_DONE;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign acc_sum = acc_q + ACC_W'($signed(in_prod));
  assign cnt_inc = cnt_q + CW'(1);
  assign close = in_last | (cnt_inc == CW'(N_TERMS));
  assign out_data = data_q;
  assign out_sat = sat_q;
  assign out_count = count_q;
  mac_round_sat #(.ACC_W(ACC_W), .FRAC(FRAC)) u_rs (
    .acc_i(acc_sum),
    .res_o(rs_data),
    .sat_o(rs_sat)
  );
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    data_d = data_q;
    sat_d = sat_q;
    count_d = count_q;
    if (in_fire) begin
      acc_d = acc_sum;
      cnt_d = cnt_inc;
      state_d = close ? ST_DONE : ST_ACCUM;
      data_d = close ? rs_data : data_q;
      sat_d = close ? rs_sat : sat_q;
      count_d = close ? cnt_inc : count_q;
    end
    if (out_fire) begin
      state_d = ST_ACCUM;
      acc_d = '0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      sat_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      sat_q <= sat_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed self-checking bench for mac_accumulator (N_TERMS=4, FRAC=8)
module tb_mac_accumulator;
  logic clk, rst, in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
  logic [33:0] in_prod;
  logic [16:0] out_data;
  logic [2:0] out_count;
  int n_vec = 0;
  int n_err = 0;
  mac_accumulator #(.N_TERMS(4), .ACC_W(40), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .out_count(out_count)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic step(input logic v, input logic signed [33:0] p, input logic l);
    in_valid = v;
    in_prod = p;
    in_last = l;
    @(negedge clk);
  endtask
  task automatic pop();
    out_ready = 1;
    step(0, 0, 0);
    out_ready = 0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL pop_out_valid got %b exp 0", out_valid); end
  endtask
  task automatic test_reset();
    rst = 1;
    step(0, 0, 0);
    rst = 0;
    n_vec++;
    if ({in_ready, out_valid, out_sat} !== 3'b100) begin n_err++; $display("FAIL reset_flags got %b exp 100", {in_ready, out_valid, out_sat}); end
    n_vec++;
    if (out_data !== 17'd0 || out_count !== 3'd0) begin n_err++; $display("FAIL reset_data got %0d/%0d exp 0/0", out_data, out_count); end
  endtask
  task automatic test_full_batch();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL full_pre%0d got rdy=%b vld=%b exp 1/0", i, in_ready, out_valid); end
      step(1, 34'sd256, 0);
    end
    in_valid = 0;
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL full_valid got vld=%b rdy=%b exp 1/0", out_valid, in_ready); end
    n_vec++;
    if (out_data !== 17'd4 || out_sat !== 1'b0 || out_count !== 3'd4) begin n_err++; $display("FAIL full_result got %0d sat=%b cnt=%0d exp 4/0/4", out_data, out_sat, out_count); end
    pop();
  endtask
  task automatic test_rounding();
    logic signed [33:0] p [4] = '{34'sd128, 34'sd127, -34'sd128, -34'sd129};
    logic [16:0] e [4] = '{17'd1, 17'd0, 17'd0, 17'h1FFFF};
    for (int i = 0; i < 4; i++) begin
      step(1, p[i], 1);
      in_valid = 0;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== e[i] || out_sat !== 1'b0 || out_count !== 3'd1) begin
        n_err++; $display("FAIL round_%0d got vld=%b data=%h sat=%b cnt=%0d exp 1/%h/0/1", p[i], out_valid, out_data, out_sat, out_count, e[i]);
      end
      pop();
    end
  endtask
  task automatic test_saturation();
    for (int i = 0; i < 4; i++) step(1, 34'sd1 << 30, 0);
    in_valid = 0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 17'h0FFFF || out_sat !== 1'b1) begin n_err++; $display("FAIL sat_pos got vld=%b data=%h sat=%b exp 1/0ffff/1", out_valid, out_data, out_sat); end
    pop();
    for (int i = 0; i < 4; i++) step(1, -(34'sd1 << 30), 0);
    in_valid = 0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 17'h10000 || out_sat !== 1'b1) begin n_err++; $display("FAIL sat_neg got vld=%b data=%h sat=%b exp 1/10000/1", out_valid, out_data, out_sat); end
    pop();
  endtask
  task automatic test_short_batch();
    step(1, 34'sd512, 0);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL short_early got vld=%b exp 0", out_valid); end
    step(1, 34'sd512, 1);
    in_valid = 0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 17'd4 || out_count !== 3'd2) begin n_err++; $display("FAIL short_result got vld=%b data=%0d cnt=%0d exp 1/4/2", out_valid, out_data, out_count); end
    pop();
    step(1, 34'sd256, 1);
    in_valid = 0;
    n_vec++;
    if (out_data !== 17'd1 || out_count !== 3'd1) begin n_err++; $display("FAIL short_next got data=%0d cnt=%0d exp 1/1", out_data, out_count); end
    pop();
  endtask
  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) step(1, 34'sd256, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 34'sd25600, 1);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 17'd4 || out_count !== 3'd4) begin
        n_err++; $display("FAIL bp_hold%0d got rdy=%b vld=%b data=%0d cnt=%0d exp 0/1/4/4", i, in_ready, out_valid, out_data, out_count);
      end
    end
    out_ready = 1;
    step(1, 34'sd25600, 1);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
    step(1, 34'sd25600, 1);
    out_ready = 0;
    in_valid = 0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 17'd100 || out_count !== 3'd1) begin n_err++; $display("FAIL bp_next got vld=%b data=%0d cnt=%0d exp 1/100/1", out_valid, out_data, out_count); end
    pop();
  endtask
  task automatic test_reset_mid_batch();
    step(1, 34'sd256, 0);
    step(1, 34'sd256, 0);
    rst = 1;
    step(1, 34'sd256, 0);
    rst = 0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_flags got vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
    for (int i = 0; i < 3; i++) begin
      step(1, 34'sd256, 0);
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_spurious%0d got vld=%b exp 0", i, out_valid); end
    end
    step(1, 34'sd256, 0);
    in_valid = 0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 17'd4 || out_count !== 3'd4) begin n_err++; $display("FAIL rstmid_result got vld=%b data=%0d cnt=%0d exp 1/4/4", out_valid, out_data, out_count); end
    rst = 1;
    step(0, 0, 0);
    rst = 0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstdone_flags got vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
  endtask
  initial begin
    rst = 1;
    in_valid = 0;
    in_prod = 0;
    in_last = 0;
    out_ready = 0;
    @(negedge clk);
    test_reset();
    test_full_batch();
    test_rounding();
    test_saturation();
    test_short_batch();
    test_backpressure();
    test_reset_mid_batch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Streaming multiply-accumulate back end that sits directly downstream of `mul`. It consumes the 34-bit signed products from `mul` one per handshake and sums a batch of up to `N_TERMS` of them in a wide accumulator. At the end of each batch it rounds away `FRAC` fraction bits, saturates the value to the 17-bit signed operand width used by `add`, `subtract` and `mul`, and presents it on a valid/ready output port. The result can be fed straight back as an operand.

## Interface
- `N_TERMS`, default 8: terms per batch. Legal range 1..2^(ACC_W-34).
- `ACC_W`, default 40: accumulator width in bits. Legal range ≥ 35.
- `FRAC`, default 8: LSBs dropped on output. Legal range 0..33.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: the product on `in_prod` is valid.
- `in_ready` output 1: the block accepts a product this cycle.
- `in_prod` input 34: signed two's-complement product from `mul`.
- `in_last` input 1: with the handshake, marks the final term of a short batch.
- `out_valid` output 1: a result is available.
- `out_ready` input 1: the consumer accepts the result.
- `out_data` output 17: rounded, saturated signed result.
- `out_sat` output 1: `out_data` was clamped.
- `out_count` output clog2(N_TERMS+1): number of terms in this result.

## Operation
- States:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- Input handshake is `in_valid & in_ready`. On each input handshake:
  - `acc <= acc + sext(in_prod)`
  - `cnt <= cnt + 1`
- ACCUM→DONE when the handshaken term makes `cnt+1 == N_TERMS`, or when `in_last`=1. On that same edge the output registers `out_data`, `out_sat` and `out_count` load the rounded and saturated final sum (the sum that includes this term).
- DONE→ACCUM on the output handshake `out_valid & out_ready`. On that edge `acc` and `cnt` clear to 0.
- While in DONE, `out_data`, `out_sat` and `out_count` stay stable until the output handshake completes.
- In ACCUM, `in_valid`=0 causes no state change. Inputs are ignored in DONE.
- Rounding is round-half-up: `r = (acc + 2^(FRAC-1)) >>> FRAC`.
  - Compute it at ACC_W+1 bits so the rounding add cannot wrap.
  - FRAC=0 means `r = acc`.
- Saturation clamps `r` to [-65536, 65535]. `out_sat`=1 exactly when a clamp occurred.
- The accumulator cannot overflow inside the legal `N_TERMS` range, so no accumulator wrap handling is required.
- Reset mid-batch discards the partial sum. Reset while in DONE drops the pending result.

## Timing
- Reset values: state=ACCUM, `acc`=0, `cnt`=0, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_sat`=0, `out_count`=0.
- Latency: `out_valid` rises on the cycle after the closing input handshake.
- Minimum batch period is terms+1 cycles, with one bubble per batch. The bubble is the DONE cycle when `out_ready`=1.
- `in_ready` is a pure function of state. It is registered and does not depend combinationally on `in_valid`.
- `out_valid` is never withdrawn once raised, and `out_data` never changes while `out_valid`=1 and `out_ready`=0.
- `rst` has priority over every handshake in the same cycle.

## Structure
- Shared package `mac_pkg` holds:
  - the state enum (`ST_ACCUM`, `ST_DONE`);
  - constants `OPND_W`=17 and `PROD_W`=34, also used by `add`, `subtract` and `mul`;
  - the saturation bounds `SAT_MAX`=65535 and `SAT_MIN`=-65536.
- One combinational sub-module, `mac_round_sat`:
  - input is the ACC_W accumulator value;
  - outputs are the 17-bit result and the sat flag;
  - parameterised by `ACC_W` and `FRAC`.

## Test plan
- N_TERMS=4, FRAC=8; four products of 256, back-to-back → one cycle after the 4th handshake: `out_valid`=1, `out_data`=4, `out_sat`=0, `out_count`=4.
- Rounding, each as a single-term batch with `in_last`=1:
  - 128 → 1
  - 127 → 0
  - -128 → 0
  - -129 → -1
- Saturation:
  - four products of 2^30 → `out_data`=65535, `out_sat`=1;
  - four products of -2^30 → `out_data`=-65536, `out_sat`=1.
- Short batch: 512, then 512 with `in_last`=1 → `out_data`=4, `out_count`=2. The next batch starts from `acc`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 →
  - `in_ready`=0 throughout, with no term accepted;
  - `out_data` stays stable;
  - after `out_ready`=1, the next term is accepted one cycle later.
- Reset after 2 of 4 terms, then a full batch of four products of 256 → result 4. No stale partial sum appears and no spurious `out_valid` is raised.
